// File: rtl/fetch_unit.sv
// Program counter sequencer for the instruction ROM.
// It runs from StartAddr, follows jumps and branches, and halts on DONE.
module fetch_unit #(
  parameter int PC_W = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            jump_en,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] Target,
  input  logic            done,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Ack,
  output logic            Running,
  output logic [15:0]     InstrCount
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PC_W-1:0] pc_n;
  logic [15:0]     cnt_n;

  assign Running = (state == RUN);

  always_comb begin
    state_n = state;
    pc_n    = ProgCtr;
    cnt_n   = InstrCount;
    if (Start) begin
      state_n = IDLE;
      pc_n    = StartAddr;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = RUN;
          cnt_n   = '0;
        end
        RUN: begin
          if (InstrCount != 16'hFFFF)
            cnt_n = InstrCount + 16'd1;
          // done outranks a redirect on the same instruction
          priority case (1'b1)
            done:                   state_n = HALT;
            (jump_en|branch_taken): pc_n    = Target;
            default:                pc_n    = ProgCtr + 1'b1;
          endcase
        end
        HALT: state_n = HALT;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      InstrCount <= '0;
      Ack        <= 1'b0;
    end else begin
      state      <= state_n;
      ProgCtr    <= pc_n;
      InstrCount <= cnt_n;
      Ack        <= (state_n == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Checks sequencing, redirects, halt, wrap, abort, reset and saturation.
module tb_fetch_unit;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [9:0] StartAddr;
  logic       jump_en;
  logic       branch_taken;
  logic [9:0] Target;
  logic       done;
  logic [9:0] ProgCtr;
  logic       Ack;
  logic       Running;
  logic [15:0] InstrCount;

  int nchk;
  int nfail;

  fetch_unit #(.PC_W(10)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .StartAddr(StartAddr),
    .jump_en(jump_en),
    .branch_taken(branch_taken),
    .Target(Target),
    .done(done),
    .ProgCtr(ProgCtr),
    .Ack(Ack),
    .Running(Running),
    .InstrCount(InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [9:0] pc,
                         input logic [15:0] cnt);
    chk({tag, ".pc"}, 32'(ProgCtr), 32'(pc));
    chk({tag, ".cnt"}, 32'(InstrCount), 32'(cnt));
    chk({tag, ".run"}, 32'(Running), 32'd1);
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    Reset = 1'b0;
    Start = 1'b0;
    StartAddr = '0;
    jump_en = 1'b0;
    branch_taken = 1'b0;
    Target = '0;
    done = 1'b0;
    #3;
    chk("rst.pc", 32'(ProgCtr), 32'd0);
    chk("rst.run", 32'(Running), 32'd0);
    chk("rst.ack", 32'(Ack), 32'd0);
    chk("rst.cnt", 32'(InstrCount), 32'd0);

    // basic sequencing from address 5
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    StartAddr = 10'd5;
    step();
    chk("idle.pc", 32'(ProgCtr), 32'd5);
    chk("idle.run", 32'(Running), 32'd0);
    step();
    Start = 1'b0;
    step();
    chk_run("seq0", 10'd5, 16'd0);
    step();
    chk_run("seq1", 10'd6, 16'd1);
    step();
    chk_run("seq2", 10'd7, 16'd2);

    // jump, branch not taken, branch taken
    jump_en = 1'b1;
    Target = 10'd40;
    step();
    chk_run("jump", 10'd40, 16'd3);
    jump_en = 1'b0;
    branch_taken = 1'b0;
    step();
    chk_run("bnt", 10'd41, 16'd4);
    branch_taken = 1'b1;
    Target = 10'd3;
    step();
    chk_run("bt", 10'd3, 16'd5);
    branch_taken = 1'b0;
    repeat (9) step();
    chk_run("pre_done", 10'd12, 16'd14);

    // done beats a simultaneous jump
    done = 1'b1;
    jump_en = 1'b1;
    Target = 10'd99;
    step();
    chk("halt.pc", 32'(ProgCtr), 32'd12);
    chk("halt.ack", 32'(Ack), 32'd1);
    chk("halt.run", 32'(Running), 32'd0);
    chk("halt.cnt", 32'(InstrCount), 32'd15);
    done = 1'b0;
    branch_taken = 1'b1;
    repeat (5) step();
    chk("hold.pc", 32'(ProgCtr), 32'd12);
    chk("hold.cnt", 32'(InstrCount), 32'd15);
    chk("hold.ack", 32'(Ack), 32'd1);
    jump_en = 1'b0;
    branch_taken = 1'b0;

    // restart from HALT, then wrap-around
    Start = 1'b1;
    StartAddr = 10'd1022;
    step();
    chk("restart.ack", 32'(Ack), 32'd0);
    chk("restart.cnt", 32'(InstrCount), 32'd0);
    chk("restart.pc", 32'(ProgCtr), 32'd1022);
    Start = 1'b0;
    step();
    chk_run("wrap0", 10'd1022, 16'd0);
    step();
    chk_run("wrap1", 10'd1023, 16'd1);
    step();
    chk_run("wrap2", 10'd0, 16'd2);
    step();
    chk_run("wrap3", 10'd1, 16'd3);

    // abort a running program at PC 20
    Start = 1'b1;
    StartAddr = 10'd17;
    step();
    Start = 1'b0;
    repeat (4) step();
    chk_run("pre_abort", 10'd20, 16'd3);
    Start = 1'b1;
    StartAddr = 10'd2;
    jump_en = 1'b1;
    Target = 10'd77;
    step();
    chk("abort.pc", 32'(ProgCtr), 32'd2);
    chk("abort.run", 32'(Running), 32'd0);
    chk("abort.cnt", 32'(InstrCount), 32'd0);
    jump_en = 1'b0;

    // asynchronous reset between edges
    Start = 1'b0;
    step();
    step();
    chk_run("pre_rst", 10'd3, 16'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst.pc", 32'(ProgCtr), 32'd0);
    chk("arst.run", 32'(Running), 32'd0);
    chk("arst.cnt", 32'(InstrCount), 32'd0);
    chk("arst.ack", 32'(Ack), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // saturation of the retired count
    Start = 1'b1;
    StartAddr = 10'd0;
    step();
    Start = 1'b0;
    step();
    chk_run("sat0", 10'd0, 16'd0);
    repeat (65535) @(posedge Clk);
    #1;
    chk("sat.cnt", 32'(InstrCount), 32'hFFFF);
    repeat (3) step();
    chk("sat.hold", 32'(InstrCount), 32'hFFFF);
    chk("sat.run", 32'(Running), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Start, input, 1, level request: high = hold/reload, high-to-low = begin execution.
REQ-004 SHALL have port StartAddr, input, 10, program entry address, sampled while Start is high.
REQ-005 SHALL have port jump_en, input, 1, unconditional jump request from the control decoder for the current instruction.
REQ-006 SHALL have port branch_taken, input, 1, resolved conditional branch (BEQ/BGE/BNE outcome) for the current instruction.
REQ-007 SHALL have port Target, input, 10, absolute redirect address from the branch lookup table.
REQ-008 SHALL have port done, input, 1, DONE decoded for the current instruction.
REQ-009 SHALL have port ProgCtr, output, 10, instruction ROM address of the current instruction.
REQ-010 SHALL have port Ack, output, 1, program halted, registered.
REQ-011 SHALL have port Running, output, 1, high only in state RUN; gates register and memory write enables downstream.
REQ-012 SHALL have port InstrCount, output, 16, number of instructions retired since the last start.
REQ-013 SHALL have parameter PC_W, default 10, width of ProgCtr, StartAddr and Target.

Function
REQ-014 SHALL implement three states: IDLE, RUN and HALT, held in a registered state variable.
REQ-015 IDLE SHALL load ProgCtr from StartAddr every cycle while Start=1, clear InstrCount to 0, and hold Ack=0 and Running=0.
REQ-016 IDLE SHALL move to RUN on the first edge at which Start=0; ProgCtr keeps the last StartAddr loaded, so the first fetch is at that address.
REQ-017 RUN SHALL update ProgCtr by priority, one update per cycle: done (hold) > jump_en|branch_taken (Target) > ProgCtr+1.
REQ-018 Sequential increment SHALL wrap modulo 2^PC_W (1023+1 -> 0), with no flag raised.
REQ-019 RUN SHALL increment InstrCount by 1 for every cycle spent in RUN, including the done cycle, saturating at 16'hFFFF.
REQ-020 done=1 in RUN SHALL move the block to HALT at the next edge, with ProgCtr frozen at the address of the DONE instruction.
REQ-021 jump_en, branch_taken and done SHALL be ignored outside RUN.
REQ-022 HALT SHALL assert Ack=1 and hold ProgCtr and InstrCount until Start=1.
REQ-023 Start=1 in any state SHALL move the block to IDLE at the next edge; this aborts a running program, and ProgCtr=StartAddr at that edge.
REQ-024 Running SHALL equal (state==RUN) combinationally; Ack SHALL equal (state==HALT), registered.
REQ-025 Redirect latency SHALL be one cycle: ProgCtr shows Target in the cycle after jump_en or branch_taken is sampled high, with no bubble or delay slot.

Reset
REQ-026 Reset=0 SHALL, asynchronously: force state=IDLE, ProgCtr=0, InstrCount=0, Ack=0 and Running=0.
REQ-027 Reset deassertion SHALL take effect at a clock edge; while Start=1 the normal IDLE behaviour then applies.
REQ-028 Reset asserted mid-RUN SHALL abandon the program immediately, without completing the update in progress.

Verification
REQ-029 Basic sequencing: Reset pulse, Start=1 with StartAddr=10'd5 for 2 cycles, then Start=0 -> ProgCtr goes 5, 6, 7, 8 on successive cycles; Running=1; InstrCount goes 1, 2, 3.
REQ-030 Jump versus branch: jump_en=1 with Target=10'd40 at PC=7 -> next PC=40; then branch_taken=0 at PC=40 -> PC=41; then branch_taken=1 with Target=10'd3 -> PC=3.
REQ-031 Simultaneous events: done=1, jump_en=1 and Target=10'd99 all at PC=12 -> PC stays 12, HALT is entered, Ack=1 the next cycle, and InstrCount is held across 5 idle cycles.
REQ-032 Wrap-around: StartAddr=10'd1022, run 3 cycles -> PC goes 1022, 1023, 0, 1.
REQ-033 Restart and abort: Start=1 in HALT -> IDLE, Ack=0, InstrCount=0; Start=1 mid-RUN at PC=20 with StartAddr=10'd2 -> PC=2 in IDLE.
REQ-034 Asynchronous reset: Reset=0 applied between clock edges during RUN -> ProgCtr=0 and Running=0 before the next edge; InstrCount saturation is checked by forcing 65535 cycles of RUN and observing 16'hFFFF held.
